arb_32b_8b: RTL and testbench
=============================

# arb_32b_8b

Two-requester round-robin scheduler in front of the 32-bit to 8-bit serializer path. Accepts 32-bit words from two independent sources over valid/ready handshakes, grants the shared byte lane to one source at a time, and emits each granted word as four consecutive bytes, MSB first, on a single clk_4f domain. Produces a word-start marker and a source tag per byte so the downstream lane and receiver can frame and demultiplex the stream.

## Interface
- IDLE_BYTE, 8'h00, value driven on data_out whenever valid_out is 0
- clk_4f  input  1  byte-rate clock; all state updates on rising edge
- reset_L  input  1  asynchronous, active-low reset
- data_in_0  input  32  word from requester 0
- valid_in_0  input  1  requester 0 has a word on data_in_0
- ready_0  output  1  arbiter accepts data_in_0 this cycle (combinational)
- data_in_1  input  32  word from requester 1
- valid_in_1  input  1  requester 1 has a word on data_in_1
- ready_1  output  1  arbiter accepts data_in_1 this cycle (combinational)
- data_out  output  8  serialized byte
- valid_out  output  1  data_out carries a payload byte
- sof_out  output  1  high with the first (MSB) byte of each word
- src_out  output  1  requester index of the word being sent

## Operation
- States: IDLE (no word in flight), SEND (byte_cnt 0..3 of a stored word).
- Acceptance point: cycle is "open" when state is IDLE, or SEND with byte_cnt == 3. Only in an open cycle may ready_0/ready_1 be high.
- Grant in an open cycle: if only one valid_in_x is high, that requester gets ready_x = 1. If both high, grant goes to the requester named by priority pointer prio. At most one ready is high per cycle.
- ready_x is a function of current state, prio and both valid_in signals only; it never depends on data_in.
- Handshake: transfer when valid_in_x && ready_x at the rising edge. Requesters must hold data_in_x and valid_in_x stable until transferred.
- On transfer: word stored in 32-bit shift register; state -> SEND, byte_cnt -> 0; data_out <= word[31:24], sof_out <= 1, src_out <= x, valid_out <= 1; prio <= ~x (other requester wins next tie).
- In SEND with byte_cnt 0..2: next edge shifts, data_out <= next byte (word[23:16], [15:8], [7:0] in order), sof_out <= 0, byte_cnt increments.
- In SEND with byte_cnt == 3 and no transfer: state -> IDLE, valid_out <= 0, sof_out <= 0, data_out <= IDLE_BYTE, src_out holds last value.
- In SEND with byte_cnt == 3 and a transfer: new word begins immediately; no idle byte inserted (gapless back-to-back).
- Single requester never starves the other: after any grant, a pending opposite request wins the next tie.

## Timing
- Reset (reset_L low, async): state IDLE, byte_cnt 0, prio 0, data_out IDLE_BYTE, valid_out 0, sof_out 0, src_out 0, shift register 0; ready_0/ready_1 follow IDLE rules combinationally (may be high during reset only if reset is deasserted; drive both 0 while reset_L low).
- Reset asserted mid-word: remaining bytes are dropped; no partial word resumes after release.
- Latency: byte 0 of an accepted word appears on data_out at the same edge that completes the handshake; bytes 1..3 on the following three edges.
- Throughput: one word per 4 clk_4f cycles under continuous demand; 100% byte-lane utilization.
- valid_in deasserted before transfer: no transfer; requests may be withdrawn without side effects.
- Both requesters idle in an open cycle: state IDLE, outputs per idle rule above.

## Test plan
- Reset then requester 0 sends 32'hFFFBBFFF alone -> data_out FF, FB, BF, FF on four consecutive edges, sof_out high on FF only, src_out 0, then valid_out 0 and data_out 8'h00.
- Requester 0 streams 32'hFFFBBFFF then 32'hDDDDDDDD back-to-back -> eight gapless valid bytes FF FB BF FF DD DD DD DD, sof_out on bytes 1 and 5, ready_0 high only in the two open cycles.
- Both valid from reset with 32'hAAAAAAAA (req 0) and 32'hDD000003 (req 1), held -> order AA AA AA AA, DD 00 00 03, src_out 0 then 1, continuous alternation while both stay valid.
- Requester 1 valid only while requester 0 holds valid constantly -> each open cycle with both pending alternates grants; requester 1 never waits more than one word.
- valid_in_0 pulsed high for a cycle mid-SEND (not open) then dropped -> no transfer, no output change, ready_0 stays 0.
- reset_L pulsed low at byte_cnt 1 of 32'hDD000003 -> outputs immediately idle values, prio 0; after release no remaining bytes emitted; next request serialized normally.

Source files
------------

// File: rtl/arb_32b_8b.sv
// ---------------------------------------------------------------------------
// arb_32b_8b
//
// Two-requester round-robin scheduler feeding a 32-bit to 8-bit serializer.
// Each requester offers 32-bit words over a valid/ready handshake. The
// arbiter grants the shared byte lane to one requester at a time and sends
// the granted word as four consecutive bytes, MSB first, all on clk_4f.
// A word-start marker (sof_out) and a source tag (src_out) go with every
// byte, so the downstream lane and receiver can frame and demultiplex the
// stream.
//
// Ports
//   clk_4f      in   1   byte-rate clock; all state changes on its rising edge
//   reset_L     in   1   asynchronous, active-low reset
//   data_in_0   in  32   word from requester 0
//   valid_in_0  in   1   requester 0 has a word on data_in_0
//   ready_0     out  1   word on data_in_0 is accepted this cycle (combinational)
//   data_in_1   in  32   word from requester 1
//   valid_in_1  in   1   requester 1 has a word on data_in_1
//   ready_1     out  1   word on data_in_1 is accepted this cycle (combinational)
//   data_out    out  8   serialized byte; IDLE_BYTE whenever valid_out is 0
//   valid_out   out  1   data_out carries a payload byte
//   sof_out     out  1   high with the first (MSB) byte of each word
//   src_out     out  1   index of the requester whose word is being sent
// ---------------------------------------------------------------------------
module arb_32b_8b #(
  parameter logic [7:0] IDLE_BYTE = 8'h00
) (
  input  logic        clk_4f,
  input  logic        reset_L,
  input  logic [31:0] data_in_0,
  input  logic        valid_in_0,
  output logic        ready_0,
  input  logic [31:0] data_in_1,
  input  logic        valid_in_1,
  output logic        ready_1,
  output logic [7:0]  data_out,
  output logic        valid_out,
  output logic        sof_out,
  output logic        src_out
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  // Registered state
  state_t      r_state;
  logic [1:0]  r_byte_cnt;
  logic        r_prio;
  logic [23:0] r_shift;
  logic [7:0]  r_data_out;
  logic        r_valid_out;
  logic        r_sof_out;
  logic        r_src_out;

  // Next-state values
  state_t      w_state_nxt;
  logic [1:0]  w_byte_cnt_nxt;
  logic        w_prio_nxt;
  logic [23:0] w_shift_nxt;
  logic [7:0]  w_data_out_nxt;
  logic        w_valid_out_nxt;
  logic        w_sof_out_nxt;
  logic        w_src_out_nxt;

  // Arbitration
  logic        w_open;
  logic        w_gnt_0;
  logic        w_gnt_1;
  logic        w_xfer;
  logic [31:0] w_word;

  // A cycle is open when the lane is idle, or when the byte currently on
  // data_out is the last one of its word. Only an open cycle may accept a
  // word, which lets a new word follow the previous one with no gap.
  assign w_open = (r_state == S_IDLE) || (r_byte_cnt == 2'd3);

  // Grant: a lone requester wins outright; on a tie the priority pointer
  // decides. The grant depends only on state, prio and the two valids, never
  // on the data. Both readies are forced low while reset is asserted.
  always_comb begin
    w_gnt_0 = reset_L && w_open && valid_in_0 && (!valid_in_1 || !r_prio);
    w_gnt_1 = reset_L && w_open && valid_in_1 && (!valid_in_0 ||  r_prio);
    w_xfer  = w_gnt_0 || w_gnt_1;
    w_word  = w_gnt_1 ? data_in_1 : data_in_0;
  end

  assign ready_0 = w_gnt_0;
  assign ready_1 = w_gnt_1;

  // Next-state and next-output logic. Everything holds by default. A
  // transfer always wins: it loads a fresh word and puts its MSB on the lane
  // at the same edge as the handshake, even when the previous word is just
  // finishing. r_shift keeps only the three bytes still to be sent, because
  // the MSB goes straight to data_out when the word is accepted.
  always_comb begin
    w_state_nxt     = r_state;
    w_byte_cnt_nxt  = r_byte_cnt;
    w_prio_nxt      = r_prio;
    w_shift_nxt     = r_shift;
    w_data_out_nxt  = r_data_out;
    w_valid_out_nxt = r_valid_out;
    w_sof_out_nxt   = r_sof_out;
    w_src_out_nxt   = r_src_out;

    if (w_xfer) begin
      w_state_nxt     = S_SEND;
      w_byte_cnt_nxt  = 2'd0;
      w_shift_nxt     = w_word[23:0];
      w_data_out_nxt  = w_word[31:24];
      w_valid_out_nxt = 1'b1;
      w_sof_out_nxt   = 1'b1;
      w_src_out_nxt   = w_gnt_1;
      // The requester just served loses the next tie.
      w_prio_nxt      = !w_gnt_1;
    end else if (r_state == S_SEND) begin
      if (r_byte_cnt != 2'd3) begin
        w_data_out_nxt = r_shift[23:16];
        w_shift_nxt    = {r_shift[15:0], 8'h00};
        w_sof_out_nxt  = 1'b0;
        w_byte_cnt_nxt = r_byte_cnt + 2'd1;
      end else begin
        // Word finished with nobody waiting: drop to idle. src_out keeps
        // the last source so the tag does not toggle on idle bytes.
        w_state_nxt     = S_IDLE;
        w_byte_cnt_nxt  = 2'd0;
        w_shift_nxt     = 24'h000000;
        w_data_out_nxt  = IDLE_BYTE;
        w_valid_out_nxt = 1'b0;
        w_sof_out_nxt   = 1'b0;
      end
    end
  end

  // State register. Reset discards any word in flight, so no partial word
  // resumes after reset is released.
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      r_state     <= S_IDLE;
      r_byte_cnt  <= 2'd0;
      r_prio      <= 1'b0;
      r_shift     <= 24'h000000;
      r_data_out  <= IDLE_BYTE;
      r_valid_out <= 1'b0;
      r_sof_out   <= 1'b0;
      r_src_out   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_byte_cnt  <= w_byte_cnt_nxt;
      r_prio      <= w_prio_nxt;
      r_shift     <= w_shift_nxt;
      r_data_out  <= w_data_out_nxt;
      r_valid_out <= w_valid_out_nxt;
      r_sof_out   <= w_sof_out_nxt;
      r_src_out   <= w_src_out_nxt;
    end
  end

  assign data_out  = r_data_out;
  assign valid_out = r_valid_out;
  assign sof_out   = r_sof_out;
  assign src_out   = r_src_out;

endmodule

// File: tb/tb_arb_32b_8b.sv
// ---------------------------------------------------------------------------
// tb_arb_32b_8b
//
// Self-checking bench for arb_32b_8b. A small reference model of the
// arbiter decides, each cycle, which requester should be granted. Granted
// words are expanded into their four expected bytes and pushed to a
// scoreboard queue; every byte the DUT drives is popped and compared.
// ---------------------------------------------------------------------------
module tb_arb_32b_8b;

  logic        clk_4f;
  logic        reset_L;
  logic [31:0] data_in_0;
  logic        valid_in_0;
  logic        ready_0;
  logic [31:0] data_in_1;
  logic        valid_in_1;
  logic        ready_1;
  logic [7:0]  data_out;
  logic        valid_out;
  logic        sof_out;
  logic        src_out;

  typedef struct packed {
    logic [7:0] data;
    logic       sof;
    logic       src;
  } exp_t;

  exp_t sbQ[$];
  logic mPrio;
  logic lastSrc;
  int   assertCount;
  int   failCount;

  arb_32b_8b dut (
    .clk_4f     (clk_4f),
    .reset_L    (reset_L),
    .data_in_0  (data_in_0),
    .valid_in_0 (valid_in_0),
    .ready_0    (ready_0),
    .data_in_1  (data_in_1),
    .valid_in_1 (valid_in_1),
    .ready_1    (ready_1),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .sof_out    (sof_out),
    .src_out    (src_out)
  );

  // Byte-rate clock, 10 time units per period.
  initial clk_4f = 1'b0;
  always #5 clk_4f = ~clk_4f;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Push the four expected bytes of a granted word, MSB first.
  task automatic pushWord(input logic [31:0] w, input logic src);
    exp_t e;
    for (int b = 3; b >= 0; b--) begin
      e.data = w[b*8 +: 8];
      e.sof  = (b == 3);
      e.src  = src;
      sbQ.push_back(e);
    end
  endtask

  // Drive one cycle of requests, check ready against the model, clock the
  // DUT and compare the byte it produces against the scoreboard.
  task automatic applyStimulus(input logic v0, input logic [31:0] d0,
                               input logic v1, input logic [31:0] d1,
                               output logic g0, output logic g1);
    logic isOpen;
    exp_t e;
    @(negedge clk_4f);
    valid_in_0 = v0;
    data_in_0  = d0;
    valid_in_1 = v1;
    data_in_1  = d1;
    #1;
    isOpen = (sbQ.size() == 0);
    g0 = isOpen && v0 && (!v1 || (mPrio == 1'b0));
    g1 = isOpen && v1 && (!v0 || (mPrio == 1'b1));
    checkOutput("ready_0", ready_0, g0);
    checkOutput("ready_1", ready_1, g1);
    if (g0) begin
      pushWord(d0, 1'b0);
      mPrio = 1'b1;
    end
    if (g1) begin
      pushWord(d1, 1'b1);
      mPrio = 1'b0;
    end
    @(posedge clk_4f);
    #1;
    if (sbQ.size() != 0) begin
      e = sbQ.pop_front();
      checkOutput("valid_out", valid_out, 1'b1);
      checkOutput("data_out", data_out, e.data);
      checkOutput("sof_out", sof_out, e.sof);
      checkOutput("src_out", src_out, e.src);
      lastSrc = e.src;
    end else begin
      checkOutput("idle_valid_out", valid_out, 1'b0);
      checkOutput("idle_data_out", data_out, 8'h00);
      checkOutput("idle_sof_out", sof_out, 1'b0);
      checkOutput("idle_src_out", src_out, lastSrc);
    end
  endtask

  task automatic idleCycles(input int n);
    logic g0, g1;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, g0, g1);
  endtask

  // Offer a word from one requester until it is granted (bounded).
  task automatic sendWord(input logic src, input logic [31:0] w);
    logic g0, g1, got;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (src) applyStimulus(1'b0, 32'h0, 1'b1, w, g0, g1);
      else     applyStimulus(1'b1, w, 1'b0, 32'h0, g0, g1);
      got = src ? g1 : g0;
    end
    checkOutput("grant_timeout", got, 1'b1);
  endtask

  // Asynchronous reset between clock edges; outputs must go idle at once
  // and both readies must stay low even with requests pending.
  task automatic applyReset();
    #2;
    valid_in_0 = 1'b1;
    valid_in_1 = 1'b1;
    reset_L    = 1'b0;
    #1;
    checkOutput("rst_valid_out", valid_out, 1'b0);
    checkOutput("rst_data_out", data_out, 8'h00);
    checkOutput("rst_sof_out", sof_out, 1'b0);
    checkOutput("rst_src_out", src_out, 1'b0);
    checkOutput("rst_ready_0", ready_0, 1'b0);
    checkOutput("rst_ready_1", ready_1, 1'b0);
    sbQ.delete();
    mPrio   = 1'b0;
    lastSrc = 1'b0;
    repeat (2) @(posedge clk_4f);
    @(negedge clk_4f);
    valid_in_0 = 1'b0;
    valid_in_1 = 1'b0;
    reset_L    = 1'b1;
  endtask

  initial begin
    logic g0, g1, pend1;
    logic [31:0] w1;
    assertCount = 0;
    failCount   = 0;
    mPrio       = 1'b0;
    lastSrc     = 1'b0;
    reset_L     = 1'b1;
    data_in_0   = 32'h0;
    data_in_1   = 32'h0;
    valid_in_0  = 1'b0;
    valid_in_1  = 1'b0;

    applyReset();
    idleCycles(2);

    $display("[TB] single word from requester 0");
    sendWord(1'b0, 32'hFFFBBFFF);
    idleCycles(5);

    $display("[TB] back-to-back words from requester 0");
    sendWord(1'b0, 32'hFFFBBFFF);
    sendWord(1'b0, 32'hDDDDDDDD);
    idleCycles(5);

    $display("[TB] both requesters held valid from reset");
    applyReset();
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 32'hAAAAAAAA, 1'b1, 32'hDD000003, g0, g1);
    idleCycles(5);

    $display("[TB] requester 0 constant, requester 1 intermittent");
    pend1 = 1'b0;
    w1    = 32'h11223344;
    for (int i = 0; i < 40; i++) begin
      if (!pend1 && ($urandom_range(0, 2) == 0)) begin
        pend1 = 1'b1;
        w1    = w1 + 32'h01010101;
      end
      applyStimulus(1'b1, 32'h5A5A0000 + i, pend1, w1, g0, g1);
      if (g1) pend1 = 1'b0;
    end
    idleCycles(5);

    $display("[TB] request pulsed while not open");
    sendWord(1'b0, 32'h01020304);
    applyStimulus(1'b1, 32'hCAFEBABE, 1'b0, 32'h0, g0, g1);
    applyStimulus(1'b0, 32'hCAFEBABE, 1'b0, 32'h0, g0, g1);
    idleCycles(4);

    $display("[TB] reset mid-word");
    sendWord(1'b1, 32'hDD000003);
    idleCycles(1);
    applyReset();
    idleCycles(4);
    // prio must be back at 0: requester 0 wins the first tie.
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 32'h0BADF00D, 1'b1, 32'h600DD00D, g0, g1);
    idleCycles(5);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
